mem_req_seq: RTL and testbench
==============================

MEM_REQ_SEQ -- requirements
Module: mem_req_seq

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 64000, number of 256-bit lines in main memory.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, maximum wait-state cycles before error (range 1..255).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  command accepted this cycle if cmd_valid is high.
REQ-007 cmd_wb  input  1  command includes a writeback.
REQ-008 cmd_fill  input  1  command includes a fill.
REQ-009 cmd_wb_addr  input  27  writeback line address.
REQ-010 cmd_wb_data  input  256  writeback data.
REQ-011 cmd_wb_be  input  32  writeback byte enables.
REQ-012 cmd_fill_addr  input  27  fill line address.
REQ-013 rsp_valid  output  1  one-cycle completion pulse.
REQ-014 rsp_err  output  1  error flag, qualified by rsp_valid.
REQ-015 rsp_data  output  256  fill data, qualified by rsp_valid with cmd_fill and no error.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 mm_a, mm_be, mm_wd, mm_write, mm_read  outputs  27/32/256/1/1  main-memory request.
REQ-018 mm_rd, mm_valid, mm_ready  inputs  256/1/1  main-memory read data, read-done, write-done.

Function
REQ-019 The block SHALL be an FSM with states IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, RESP.
REQ-020 cmd_ready SHALL equal (state==IDLE) and be low while rst is high; acceptance = cmd_valid & cmd_ready at an edge; all cmd_* fields captured into registers.
REQ-021 On acceptance, next state SHALL be WB_REQ if cmd_wb, else RD_REQ if cmd_fill, else RESP with error.
REQ-022 An accepted address >= ENTRIES (wb or fill, whichever is used) SHALL go to RESP with error, no memory access issued.
REQ-023 mm_write SHALL be high exactly one cycle, in WB_REQ; mm_read exactly one cycle, in RD_REQ; never both; both registered-state decodes.
REQ-024 mm_a/mm_be/mm_wd SHALL be driven from captured registers and held stable from the REQ cycle until the matching WAIT state exits; mm_a = wb_addr in WB_*, fill_addr in RD_*.
REQ-025 WB_WAIT SHALL exit on mm_ready high: to RD_REQ if fill, else RESP; mm_valid ignored there.
REQ-026 RD_WAIT SHALL exit on mm_valid high, capturing mm_rd into rsp_data, to RESP; mm_ready ignored there.
REQ-027 A wait counter SHALL clear on entry to each WAIT state and increment each WAIT cycle; reaching TIMEOUT without the done signal SHALL go to RESP with error.
REQ-028 RESP SHALL assert rsp_valid for one cycle, rsp_err per recorded error, then go to IDLE.
REQ-029 Latency from acceptance edge: fill-only rsp_valid 4 cycles later, wb-only 4, wb+fill 7 (against 2-cycle-latency memory).
REQ-030 mm_valid/mm_ready arriving in IDLE, REQ or RESP states SHALL be ignored.
REQ-031 rsp_data SHALL hold its value until the next fill capture.

Reset
REQ-032 With rst high at an edge: state=IDLE, counter=0, error flag=0; mm_read=mm_write=rsp_valid=rsp_err=busy=cmd_ready=0 in the following cycle; rsp_data=0; mm_a/mm_be/mm_wd=0.
REQ-033 rst mid-transaction SHALL abort without a response; late memory done signals SHALL be ignored per REQ-030.

Verification
REQ-034 Fill-only addr 0x10 (mem line 0x10 = pattern P): mm_read one cycle at accept+1, rsp_valid at accept+4, rsp_data=P, rsp_err=0.
REQ-035 WB+fill wb_addr 0x3, be=all-ones, data D, fill_addr 0x3: mm_write at +1, mm_read at +4, rsp_valid at +7, rsp_data=D.
REQ-036 Fill addr 64000: no mm_read, rsp_valid at +2 with rsp_err=1.
REQ-037 Memory model stuck (mm_valid never high), TIMEOUT=15: rsp_valid with rsp_err=1 at accept+1+1+15+1.
REQ-038 rst asserted in RD_WAIT: no rsp_valid, busy=0, next cmd accepted normally.
REQ-039 Back-to-back cmd_valid held high: second cmd accepted the cycle after first rsp_valid, cmd_ready low throughout first.

Source files
------------

// File: rtl/mem_req_seq_if.sv
// mem_req_seq_if: command/response and main-memory signal bundle for mem_req_seq
interface mem_req_seq_if;
  logic cmd_valid, cmd_ready, cmd_wb, cmd_fill;
  logic [26:0] cmd_wb_addr, cmd_fill_addr;
  logic [255:0] cmd_wb_data;
  logic [31:0] cmd_wb_be;
  logic rsp_valid, rsp_err, busy;
  logic [255:0] rsp_data;
  logic [26:0] mm_a;
  logic [31:0] mm_be;
  logic [255:0] mm_wd, mm_rd;
  logic mm_write, mm_read, mm_valid, mm_ready;
  modport master (
    output cmd_valid, cmd_wb, cmd_fill, cmd_wb_addr, cmd_wb_data, cmd_wb_be, cmd_fill_addr, mm_rd, mm_valid, mm_ready,
    input cmd_ready, rsp_valid, rsp_err, rsp_data, busy, mm_a, mm_be, mm_wd, mm_write, mm_read
  );
  modport slave (
    input cmd_valid, cmd_wb, cmd_fill, cmd_wb_addr, cmd_wb_data, cmd_wb_be, cmd_fill_addr, mm_rd, mm_valid, mm_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_data, busy, mm_a, mm_be, mm_wd, mm_write, mm_read
  );
endinterface

// File: rtl/mem_req_seq.sv
// mem_req_seq: single-outstanding writeback/fill sequencer to main memory with timeout
module mem_req_seq #(
  parameter int ENTRIES = 64000,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  mem_req_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, RESP} state_t;
  localparam logic [31:0] ENT = 32'(ENTRIES);
  localparam logic [7:0] TO = 8'(TIMEOUT);
  state_t state, state_nx;
  logic fill, err, err_nx, acc, wb_bad, fill_bad, tmo;
  logic [26:0] wb_addr, fill_addr;
  logic [255:0] wb_data, rsp_data;
  logic [31:0] wb_be;
  logic [7:0] cnt;
  assign acc = bus.cmd_valid && state == IDLE;
  assign wb_bad = 32'(wb_addr) >= ENT;
  assign fill_bad = 32'(fill_addr) >= ENT;
  assign tmo = cnt == TO;
  always_comb begin
    state_nx = state;
    err_nx = err;
    case (state)
      IDLE: if (acc) begin
        state_nx = bus.cmd_wb ? WB_REQ : bus.cmd_fill ? RD_REQ : RESP;
        err_nx = !(bus.cmd_wb || bus.cmd_fill);
      end
      WB_REQ: if (wb_bad) begin
        state_nx = RESP;
        err_nx = 1'b1;
      end else state_nx = WB_WAIT;
      WB_WAIT: if (bus.mm_ready) state_nx = fill ? RD_REQ : RESP;
      else if (tmo) begin
        state_nx = RESP;
        err_nx = 1'b1;
      end
      RD_REQ: if (fill_bad) begin
        state_nx = RESP;
        err_nx = 1'b1;
      end else state_nx = RD_WAIT;
      RD_WAIT: if (bus.mm_valid) state_nx = RESP;
      else if (tmo) begin
        state_nx = RESP;
        err_nx = 1'b1;
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      err <= 1'b0;
      cnt <= '0;
      fill <= 1'b0;
      wb_addr <= '0;
      fill_addr <= '0;
      wb_data <= '0;
      wb_be <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_nx;
      err <= err_nx;
      cnt <= (state == WB_WAIT || state == RD_WAIT) ? cnt + 8'd1 : '0;
      if (acc) begin
        fill <= bus.cmd_fill;
        wb_addr <= bus.cmd_wb_addr;
        fill_addr <= bus.cmd_fill_addr;
        wb_data <= bus.cmd_wb_data;
        wb_be <= bus.cmd_wb_be;
      end
      if (state == RD_WAIT && bus.mm_valid) rsp_data <= bus.mm_rd;
    end
  end
  assign bus.cmd_ready = state == IDLE && !rst;
  assign bus.busy = state != IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_err = state == RESP && err;
  assign bus.rsp_data = rsp_data;
  assign bus.mm_write = state == WB_REQ && !wb_bad;
  assign bus.mm_read = state == RD_REQ && !fill_bad;
  assign bus.mm_a = (state == WB_REQ || state == WB_WAIT) ? wb_addr : fill_addr;
  assign bus.mm_be = wb_be;
  assign bus.mm_wd = wb_data;
endmodule

// File: tb/tb_mem_req_seq.sv
// tb_mem_req_seq: table, hand-written and random checks of mem_req_seq against a transaction-level model
module tb_mem_req_seq;
  localparam int ENTRIES = 64000;
  localparam int TIMEOUT = 15;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_req_seq_if bus();
  mem_req_seq #(.ENTRIES(ENTRIES), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  int lat_w = 2;
  int lat_r = 2;
  int wr_dly = 0;
  int rd_dly = 0;
  logic noise = 1'b0;
  logic [26:0] rd_a = '0;
  logic [255:0] mem [int];
  logic [255:0] ref_mem [int];
  logic [255:0] exp_data = '0;
  typedef struct {
    logic wb, fill;
    logic [26:0] wa;
    logic [31:0] be;
    logic [26:0] fa;
    int lw, lr, rsp, err, wc, rc;
  } vec_t;
  vec_t vt [14];
  function automatic logic [255:0] pat(int a);
    return {8{32'(a) * 32'h9e3779b1 ^ 32'h5a5a0000}};
  endfunction
  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic logic [255:0] merge(logic [255:0] o, logic [255:0] n, logic [31:0] be);
    for (int i = 0; i < 32; i++) if (be[i]) o[i*8 +: 8] = n[i*8 +: 8];
    return o;
  endfunction
  function automatic logic [255:0] mem_line(int a);
    return mem.exists(a) ? mem[a] : pat(a);
  endfunction
  function automatic logic [255:0] ref_line(int a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction
  // memory: acts on strobes seen at the falling edge, answers lat edges later; lat 0 = never answers
  always @(negedge clk) begin
    bus.mm_valid = noise;
    bus.mm_ready = noise;
    bus.mm_rd = rnd256();
    if (wr_dly > 0) begin
      wr_dly--;
      if (wr_dly == 0) bus.mm_ready = 1'b1;
    end
    if (rd_dly > 0) begin
      rd_dly--;
      if (rd_dly == 0) begin
        bus.mm_valid = 1'b1;
        bus.mm_rd = mem_line(int'(rd_a));
      end
    end
    if (bus.mm_write && lat_w != 0) begin
      mem[int'(bus.mm_a)] = merge(mem_line(int'(bus.mm_a)), bus.mm_wd, bus.mm_be);
      wr_dly = lat_w;
    end
    if (bus.mm_read && lat_r != 0) begin
      rd_a = bus.mm_a;
      rd_dly = lat_r;
    end
  end
  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // transaction-level expectation: edges after acceptance for strobes and response, plus memory/data effects
  task automatic ref_txn(input logic wb, fill, input logic [26:0] wa, input logic [255:0] wd, input logic [31:0] be,
                         input logic [26:0] fa, input int lw, lr, output int rsp, err, wc, rc);
    int t;
    t = 0;
    err = 0;
    wc = 0;
    rc = 0;
    if (!wb && !fill) err = 1;
    if (wb) begin
      if (wa >= ENTRIES) begin
        err = 1;
        t = 1;
      end else begin
        wc = 1;
        if (lw != 0) ref_mem[int'(wa)] = merge(ref_line(int'(wa)), wd, be);
        if (lw == 0 || lw > TIMEOUT + 1) begin
          err = 1;
          t = TIMEOUT + 2;
        end else t = 1 + lw;
      end
    end
    if (fill && err == 0) begin
      if (fa >= ENTRIES) begin
        err = 1;
        t += 1;
      end else begin
        rc = t + 1;
        if (lr == 0 || lr > TIMEOUT + 1) begin
          err = 1;
          t += TIMEOUT + 2;
        end else begin
          t += 1 + lr;
          exp_data = ref_line(int'(fa));
        end
      end
    end
    rsp = t + 1;
  endtask
  task automatic run_cmd(string tag, logic wb, fill, logic [26:0] wa, logic [255:0] wd, logic [31:0] be,
                         logic [26:0] fa, int lw, lr, e_rsp, e_err, e_wc, e_rc);
    int fw, nw, fr, nr, got;
    logic [26:0] aw, ar;
    logic err;
    fw = 0; nw = 0; fr = 0; nr = 0; got = 0; aw = '0; ar = '0; err = 1'b0;
    lat_w = lw;
    lat_r = lr;
    bus.cmd_wb = wb;
    bus.cmd_fill = fill;
    bus.cmd_wb_addr = wa;
    bus.cmd_wb_data = wd;
    bus.cmd_wb_be = be;
    bus.cmd_fill_addr = fa;
    bus.cmd_valid = 1'b1;
    chk({tag, " ready"}, bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_wb_addr = 27'($urandom);
    bus.cmd_fill_addr = 27'($urandom);
    bus.cmd_wb_data = rnd256();
    for (int n = 1; n <= 60 && got == 0; n++) begin
      @(negedge clk);
      if (n == 1) chk({tag, " busy"}, bus.busy, 1);
      if (bus.mm_write) begin
        nw++;
        if (fw == 0) begin fw = n; aw = bus.mm_a; end
      end
      if (bus.mm_read) begin
        nr++;
        if (fr == 0) begin fr = n; ar = bus.mm_a; end
      end
      if (bus.rsp_valid) begin
        got = n;
        err = bus.rsp_err;
        chk({tag, " rsp_data"}, bus.rsp_data, exp_data);
      end
    end
    chk({tag, " rsp_cycle"}, got, e_rsp);
    chk({tag, " rsp_err"}, err, e_err);
    chk({tag, " write_cycle"}, fw, e_wc);
    chk({tag, " write_count"}, nw, e_wc != 0);
    chk({tag, " read_cycle"}, fr, e_rc);
    chk({tag, " read_count"}, nr, e_rc != 0);
    if (fw != 0) chk({tag, " write_addr"}, aw, wa);
    if (fr != 0) chk({tag, " read_addr"}, ar, fa);
    @(negedge clk);
    chk({tag, " rsp_pulse"}, {bus.rsp_valid, bus.busy}, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    logic [255:0] wd, da, db;
    logic [26:0] wa, fa;
    logic wb, fill;
    int lw, lr, rsp, err, wc, rc, cnt;
    vt[0]  = '{1'b0, 1'b1, 27'd0,     32'h0,        27'h10,    2, 2,  4, 0, 0, 1};
    vt[1]  = '{1'b1, 1'b1, 27'h3,     32'hffffffff, 27'h3,     2, 2,  7, 0, 1, 4};
    vt[2]  = '{1'b0, 1'b1, 27'd0,     32'h0,        27'd64000, 2, 2,  2, 1, 0, 0};
    vt[3]  = '{1'b0, 1'b1, 27'd0,     32'h0,        27'h20,    2, 0, 18, 1, 0, 1};
    vt[4]  = '{1'b1, 1'b0, 27'h5,     32'h0000ffff, 27'd0,     2, 2,  4, 0, 1, 0};
    vt[5]  = '{1'b0, 1'b0, 27'h7,     32'hffffffff, 27'h7,     2, 2,  1, 1, 0, 0};
    vt[6]  = '{1'b1, 1'b1, 27'd64000, 32'hffffffff, 27'h1,     2, 2,  2, 1, 0, 0};
    vt[7]  = '{1'b1, 1'b1, 27'h6,     32'hffffffff, 27'd64001, 2, 2,  5, 1, 1, 0};
    vt[8]  = '{1'b0, 1'b1, 27'd0,     32'h0,        27'd63999, 2, 1,  3, 0, 0, 1};
    vt[9]  = '{1'b0, 1'b1, 27'd0,     32'h0,        27'h5,     2, 16, 18, 0, 0, 1};
    vt[10] = '{1'b0, 1'b1, 27'd0,     32'h0,        27'h5,     2, 17, 18, 1, 0, 1};
    vt[11] = '{1'b1, 1'b1, 27'h8,     32'hffffffff, 27'h8,     0, 2, 18, 1, 1, 0};
    vt[12] = '{1'b1, 1'b1, 27'h9,     32'hffffffff, 27'h5,     3, 1,  7, 0, 1, 5};
    vt[13] = '{1'b1, 1'b1, 27'h4,     32'h0f0f0f0f, 27'h4,     1, 2,  6, 0, 1, 3};
    bus.cmd_valid = 1'b1;
    bus.cmd_wb = 1'b0;
    bus.cmd_fill = 1'b1;
    bus.cmd_wb_addr = '0;
    bus.cmd_fill_addr = 27'h10;
    bus.cmd_wb_data = '0;
    bus.cmd_wb_be = '0;
    repeat (3) @(negedge clk);
    chk("reset cmd_ready", bus.cmd_ready, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset rsp", {bus.rsp_valid, bus.rsp_err}, 0);
    chk("reset strobes", {bus.mm_read, bus.mm_write}, 0);
    chk("reset rsp_data", bus.rsp_data, 0);
    chk("reset mm_a", bus.mm_a, 0);
    chk("reset mm_be", bus.mm_be, 0);
    chk("reset mm_wd", bus.mm_wd, 0);
    bus.cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle cmd_ready", bus.cmd_ready, 1);
    noise = 1'b1;
    repeat (3) @(negedge clk);
    noise = 1'b0;
    chk("idle noise busy", bus.busy, 0);
    chk("idle noise rsp_data", bus.rsp_data, 0);
    for (int i = 0; i < 14; i++) begin
      wd = rnd256();
      ref_txn(vt[i].wb, vt[i].fill, vt[i].wa, wd, vt[i].be, vt[i].fa, vt[i].lw, vt[i].lr, rsp, err, wc, rc);
      run_cmd($sformatf("vec%0d", i), vt[i].wb, vt[i].fill, vt[i].wa, wd, vt[i].be, vt[i].fa, vt[i].lw, vt[i].lr,
              vt[i].rsp, vt[i].err, vt[i].wc, vt[i].rc);
    end
    lat_r = 5;
    bus.cmd_wb = 1'b0;
    bus.cmd_fill = 1'b1;
    bus.cmd_fill_addr = 27'h10;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_data = '0;
    chk("abort busy", bus.busy, 0);
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.busy) cnt++;
    end
    chk("abort no response", cnt, 0);
    chk("abort rsp_data", bus.rsp_data, 0);
    ref_txn(1'b0, 1'b1, '0, '0, '0, 27'h11, 2, 2, rsp, err, wc, rc);
    run_cmd("after abort", 1'b0, 1'b1, '0, '0, '0, 27'h11, 2, 2, 4, 0, 0, 1);
    ref_txn(1'b0, 1'b1, '0, '0, '0, 27'h3, 2, 2, rsp, err, wc, rc);
    da = exp_data;
    ref_txn(1'b0, 1'b1, '0, '0, '0, 27'h9, 2, 2, rsp, err, wc, rc);
    db = exp_data;
    lat_r = 2;
    bus.cmd_fill_addr = 27'h3;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_fill_addr = 27'h9;
    cnt = 0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (bus.cmd_ready) cnt++;
    end
    chk("b2b ready low", cnt, 0);
    chk("b2b first rsp", bus.rsp_valid, 1);
    chk("b2b first data", bus.rsp_data, da);
    @(negedge clk);
    chk("b2b second ready", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b second rsp", bus.rsp_valid, 1);
    chk("b2b second data", bus.rsp_data, db);
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      wb = 1'($urandom_range(0, 1));
      fill = 1'($urandom_range(0, 3) != 0);
      wa = ($urandom_range(0, 4) == 0) ? 27'(63998 + $urandom_range(0, 4)) : 27'($urandom_range(0, 15));
      fa = ($urandom_range(0, 4) == 0) ? 27'(63998 + $urandom_range(0, 4)) : 27'($urandom_range(0, 15));
      cnt = $urandom_range(0, 19);
      lw = cnt == 0 ? 0 : cnt == 1 ? 16 : cnt == 2 ? 17 : 1 + cnt % 3;
      cnt = $urandom_range(0, 19);
      lr = cnt == 0 ? 0 : cnt == 1 ? 16 : cnt == 2 ? 17 : 1 + cnt % 3;
      wd = rnd256();
      da = rnd256();
      ref_txn(wb, fill, wa, wd, da[31:0], fa, lw, lr, rsp, err, wc, rc);
      run_cmd($sformatf("rnd%0d", i), wb, fill, wa, wd, da[31:0], fa, lw, lr, rsp, err, wc, rc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
